// File: rtl/seg7_capture.sv
// Receive-side monitor for a multiplexed 4-digit active-low 7-segment bus.
// Resynchronises the bus, captures each settled digit once, and rebuilds MM:SS in binary.
module seg7_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] digit_bcd,
    output logic [3:0]  blank_mask,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic        frame_valid,
    output logic        frame_clean,
    output logic        err_seg,
    output logic        err_anode,
    output logic        err_range
);

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_t;

    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [10:0]      sync_a;
    logic [10:0]      sync_b;
    logic [10:0]      prev_bus;
    logic [CNT_W-1:0] stable_cnt;
    logic [3:0]       seen;
    logic [3:0]       pending_blank;
    logic             dirty;

    logic             bus_change;
    logic [3:0]       dec_val;
    logic             dec_digit;
    logic             dec_blank;
    logic [1:0]       digit_idx;
    logic             anode_hit;
    logic             anode_bad;
    logic             frame_done;
    logic [6:0]       min_full;
    logic [6:0]       sec_full;
    logic             out_of_range;
    logic [3:0]       seen_next;
    logic [3:0]       blank_next;
    logic             dirty_next;

    assign bus_change   = (sync_b != prev_bus);
    assign frame_done   = (seen == 4'b1111);
    assign min_full     = 7'(digit_bcd[15:12]) * 7'd10 + 7'(digit_bcd[11:8]);
    assign sec_full     = 7'(digit_bcd[7:4]) * 7'd10 + 7'(digit_bcd[3:0]);
    assign out_of_range = (min_full > 7'd59) || (sec_full > 7'd59);

    // Decode the value held in prev_bus; it is the settled value whenever the FSM is in CAPTURE.
    always_comb begin
        dec_val   = 4'd0;
        dec_digit = 1'b1;
        dec_blank = 1'b0;
        case (prev_bus[6:0])
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: begin
                dec_digit = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_digit = 1'b0;
        endcase

        digit_idx = 2'd0;
        anode_hit = 1'b1;
        anode_bad = 1'b0;
        case (prev_bus[10:7])
            4'b0111: digit_idx = 2'd3;
            4'b1011: digit_idx = 2'd2;
            4'b1101: digit_idx = 2'd1;
            4'b1110: digit_idx = 2'd0;
            4'b1111: anode_hit = 1'b0;
            default: begin
                anode_hit = 1'b0;
                anode_bad = 1'b1;
            end
        endcase
    end

    // A completing frame empties the bookkeeping first, so a capture in that same cycle starts the next frame.
    always_comb begin
        seen_next  = frame_done ? 4'b0000 : seen;
        blank_next = frame_done ? 4'b0000 : pending_blank;
        dirty_next = frame_done ? 1'b0 : dirty;
        if (state == ST_CAPTURE) begin
            if (anode_hit) begin
                seen_next[digit_idx]  = 1'b1;
                blank_next[digit_idx] = dec_blank;
                if (!dec_digit && !dec_blank)
                    dirty_next = 1'b1;
            end else if (anode_bad) begin
                dirty_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a     <= '0;
            sync_b     <= '0;
            prev_bus   <= '0;
            stable_cnt <= '0;
        end else begin
            sync_a   <= {anode_in, seg_in};
            sync_b   <= sync_a;
            prev_bus <= sync_b;
            if (bus_change)
                stable_cnt <= '0;
            else if (stable_cnt < SETTLE_MAX)
                stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // One capture per stable period; a change seen during CAPTURE goes straight back to settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            case (state)
                ST_WAIT:    if (bus_change) state <= ST_SETTLE;
                ST_SETTLE:  if (!bus_change && stable_cnt == SETTLE_LAST) state <= ST_CAPTURE;
                ST_CAPTURE: state <= bus_change ? ST_SETTLE : ST_HOLD;
                ST_HOLD:    if (bus_change) state <= ST_SETTLE;
                default:    state <= ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen          <= '0;
            pending_blank <= '0;
            dirty         <= 1'b0;
            digit_bcd     <= '0;
            blank_mask    <= '0;
            minutes       <= '0;
            seconds       <= '0;
            frame_valid   <= 1'b0;
            frame_clean   <= 1'b0;
            err_seg       <= 1'b0;
            err_anode     <= 1'b0;
            err_range     <= 1'b0;
        end else begin
            seen          <= seen_next;
            pending_blank <= blank_next;
            dirty         <= dirty_next;
            frame_valid   <= frame_done;
            frame_clean   <= frame_done && (pending_blank == 4'b0000) && !dirty && !out_of_range;
            if (frame_done) begin
                blank_mask <= pending_blank;
                if (out_of_range)
                    err_range <= 1'b1;
                if ((pending_blank == 4'b0000) && !dirty && !out_of_range) begin
                    minutes <= min_full[5:0];
                    seconds <= sec_full[5:0];
                end
            end
            if (state == ST_CAPTURE) begin
                if (anode_hit) begin
                    digit_bcd[{digit_idx, 2'b00} +: 4] <= dec_digit ? dec_val : 4'd0;
                    if (!dec_digit && !dec_blank)
                        err_seg <= 1'b1;
                end else if (anode_bad) begin
                    err_anode <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a frame-level scoreboard predicts every frame report,
// and literal checks after each scenario pin the scoreboard itself.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anode_in;
    logic [6:0]  seg_in;
    logic [15:0] digit_bcd;
    logic [3:0]  blank_mask;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        frame_valid;
    logic        frame_clean;
    logic        err_seg;
    logic        err_anode;
    logic        err_range;

    always #5 clk = ~clk;

    seg7_capture #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .anode_in(anode_in), .seg_in(seg_in),
        .digit_bcd(digit_bcd), .blank_mask(blank_mask), .minutes(minutes), .seconds(seconds),
        .frame_valid(frame_valid), .frame_clean(frame_clean),
        .err_seg(err_seg), .err_anode(err_anode), .err_range(err_range)
    );

    typedef struct {
        bit         clean;
        logic [3:0] blanks;
        int         min_v;
        int         sec_v;
    } frame_t;

    localparam int DIGIT_HOLD = 20;
    localparam int GAP_HOLD   = 10;
    localparam int BLANK      = 10;
    localparam int BAD        = 11;

    int         compared   = 0;
    int         mismatched = 0;
    bit         checking   = 1'b0;
    frame_t     frame_q[$];
    int         mdl_digit[4];
    logic [3:0] mdl_seen;
    logic [3:0] mdl_blank;
    bit         mdl_dirty;
    bit         exp_err_seg;
    bit         exp_err_anode;
    bit         exp_err_range;
    int         exp_min;
    int         exp_sec;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            BLANK: return 7'b1111111;
            default: return 7'b1010101;
        endcase
    endfunction

    task automatic model_clear();
        frame_q.delete();
        for (int i = 0; i < 4; i++) mdl_digit[i] = 0;
        mdl_seen = 4'b0000;
        mdl_blank = 4'b0000;
        mdl_dirty = 1'b0;
        exp_err_seg = 1'b0;
        exp_err_anode = 1'b0;
        exp_err_range = 1'b0;
        exp_min = 0;
        exp_sec = 0;
    endtask

    // Frame-level view: a digit held long enough counts once; four distinct digits make a frame.
    task automatic model_capture(input int pos, input int val);
        frame_t f;
        mdl_seen[pos]  = 1'b1;
        mdl_digit[pos] = (val < 10) ? val : 0;
        mdl_blank[pos] = (val == BLANK);
        if (val == BAD) begin
            mdl_dirty = 1'b1;
            exp_err_seg = 1'b1;
        end
        if (mdl_seen == 4'b1111) begin
            f.min_v  = mdl_digit[3] * 10 + mdl_digit[2];
            f.sec_v  = mdl_digit[1] * 10 + mdl_digit[0];
            f.blanks = mdl_blank;
            f.clean  = (mdl_blank == 4'b0000) && !mdl_dirty && f.min_v <= 59 && f.sec_v <= 59;
            if (f.min_v > 59 || f.sec_v > 59) exp_err_range = 1'b1;
            frame_q.push_back(f);
            mdl_seen  = 4'b0000;
            mdl_blank = 4'b0000;
            mdl_dirty = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int hold);
        anode_in = a;
        seg_in   = s;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic show_digit(input int pos, input int val);
        logic [3:0] a;
        a = ~(4'b0001 << pos);
        model_capture(pos, val);
        applyStimulus(a, seg_of(val), DIGIT_HOLD);
        applyStimulus(4'b1111, 7'b1111111, GAP_HOLD);
    endtask

    task automatic scan_time(input int m, input int s);
        show_digit(3, m / 10);
        show_digit(2, m % 10);
        show_digit(1, s / 10);
        show_digit(0, s % 10);
        checkOutput("frames outstanding", frame_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset digit_bcd", digit_bcd, 0);
        checkOutput("reset blank_mask", blank_mask, 0);
        checkOutput("reset minutes", minutes, 0);
        checkOutput("reset seconds", seconds, 0);
        checkOutput("reset frame_valid", frame_valid, 0);
        checkOutput("reset frame_clean", frame_clean, 0);
        checkOutput("reset errors", {err_seg, err_anode, err_range}, 0);
        rst = 1'b0;
    endtask

    // Every cycle: frame reports must match the scoreboard and MM:SS must hold between clean frames.
    always @(negedge clk) begin : compare_proc
        frame_t f;
        if (checking && !rst) begin
            if (frame_valid) begin
                if (frame_q.size() == 0) begin
                    checkOutput("unexpected frame_valid", 1, 0);
                end else begin
                    f = frame_q.pop_front();
                    checkOutput("frame_clean", frame_clean, f.clean);
                    checkOutput("blank_mask", blank_mask, f.blanks);
                    checkOutput("err_seg at frame", err_seg, exp_err_seg);
                    checkOutput("err_anode at frame", err_anode, exp_err_anode);
                    checkOutput("err_range at frame", err_range, exp_err_range);
                    if (f.clean) begin
                        exp_min = f.min_v;
                        exp_sec = f.sec_v;
                    end
                end
            end
            checkOutput("minutes", minutes, exp_min);
            checkOutput("seconds", seconds, exp_sec);
        end
    end

    initial begin
        rst = 1'b1;
        anode_in = 4'b1111;
        seg_in = 7'b1111111;
        @(posedge clk);
        #1;
        do_reset();
        checking = 1'b1;
        applyStimulus(4'b1111, 7'b1111111, GAP_HOLD);

        $display("[TB] scenario: clean frame 12:34");
        scan_time(12, 34);
        checkOutput("t1 minutes", minutes, 12);
        checkOutput("t1 seconds", seconds, 34);
        checkOutput("t1 digit_bcd", digit_bcd, 16'h1234);
        checkOutput("t1 blank_mask", blank_mask, 0);

        $display("[TB] scenario: glitching D0 settles on 5");
        for (int k = 0; k < 5; k++)
            applyStimulus(4'b1110, seg_of((k < 4) ? k + 1 : 6), 2);
        show_digit(0, 5);
        checkOutput("t2 D0", digit_bcd[3:0], 5);
        checkOutput("t2 err_seg", err_seg, 0);
        show_digit(3, 1);
        show_digit(2, 2);
        show_digit(1, 3);
        checkOutput("t2 frames outstanding", frame_q.size(), 0);
        checkOutput("t2 minutes", minutes, 12);
        checkOutput("t2 seconds", seconds, 35);

        $display("[TB] scenario: blinking seconds");
        show_digit(3, 5);
        show_digit(2, 9);
        show_digit(1, BLANK);
        show_digit(0, BLANK);
        checkOutput("t3 blank_mask", blank_mask, 4'b0011);
        checkOutput("t3 minutes", minutes, 12);
        checkOutput("t3 seconds", seconds, 35);

        $display("[TB] scenario: bad segment and anode codes");
        show_digit(3, 1);
        show_digit(2, BAD);
        checkOutput("t4 err_seg", err_seg, 1);
        exp_err_anode = 1'b1;
        mdl_dirty = 1'b1;
        applyStimulus(4'b0011, 7'b1111111, DIGIT_HOLD);
        applyStimulus(4'b1111, 7'b1111111, GAP_HOLD);
        checkOutput("t4 err_anode", err_anode, 1);
        show_digit(1, 0);
        show_digit(0, 0);
        checkOutput("t4 frames outstanding", frame_q.size(), 0);
        checkOutput("t4 err_seg sticky", err_seg, 1);
        checkOutput("t4 blank_mask", blank_mask, 0);
        checkOutput("t4 minutes", minutes, 12);

        $display("[TB] scenario: out of range then 59:59");
        scan_time(75, 0);
        checkOutput("t5 err_range", err_range, 1);
        checkOutput("t5 minutes held", minutes, 12);
        scan_time(59, 59);
        checkOutput("t5 minutes", minutes, 59);
        checkOutput("t5 seconds", seconds, 59);

        $display("[TB] scenario: reset mid-frame");
        show_digit(3, 2);
        show_digit(2, 3);
        do_reset();
        applyStimulus(4'b1111, 7'b1111111, GAP_HOLD);
        checkOutput("t6 idle frame_valid", frame_valid, 0);
        scan_time(1, 2);
        checkOutput("t6 minutes", minutes, 1);
        checkOutput("t6 seconds", seconds, 2);
        checkOutput("t6 errors", {err_seg, err_anode, err_range}, 0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
